product_ram_reader: RTL

- Read-side companion to the multiplier datapath. The multiplier writes 8-bit products into the 8-entry result RAM; this block reads them back out.
- On a start command it reads a run of consecutive RAM entries and presents each one on a valid/ready output stream, tagged with its address.
- Sits between the result RAM's read port and the display/debug consumer, in the same clock domain as Multiplier_top.

---
 rtl/product_ram_reader.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/product_ram_reader.sv
// product_ram_reader: reads a run of consecutive result-RAM entries and streams
// each word, tagged with its address, on a valid/ready interface.
// One RAM read is outstanding at most; a word is issued, captured, then held
// until the consumer takes it.
// Optional feature macro: PRODUCT_READER_CHECKSUM_EN adds a running modulo-2**DW
// sum of the accepted words on the checksum port. When the macro is undefined,
// checksum is tied to zero.
// done is high during the DONE state cycle, which is the cycle right after the
// last handshake, or the cycle right after the start edge when count is zero.
module product_ram_reader #(
    parameter int unsigned DW = 8,
    parameter int unsigned AW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] start_adr,
    input  logic [AW:0]   count,
    output logic          ram_rd,
    output logic [AW-1:0] ram_adr,
    input  logic [DW-1:0] ram_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [AW-1:0] out_adr,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] checksum,
    output logic [3:0]    st_out
);

    localparam int unsigned Depth    = 2 ** AW;
    localparam logic [AW:0] MaxCount = (AW + 1)'(Depth);

    // State codes double as the debug code on st_out.
    typedef enum logic [3:0] {
        StIdle  = 4'b0000,
        StIssue = 4'b0001,
        StWait  = 4'b0010,
        StHold  = 4'b0100,
        StDone  = 4'b1000
    } state_e;

    state_e        state_q;
    logic [AW-1:0] ptr_q;
    logic [AW:0]   remaining_q;
    logic [AW:0]   count_clamped;
    logic          accept;
    logic          handshake;

    // Counts beyond the RAM depth are clamped to a full-RAM dump.
    assign count_clamped = (count > MaxCount) ? MaxCount : count;
    assign accept        = (state_q == StIdle) && start;
    assign handshake     = (state_q == StHold) && out_valid && out_ready;
    assign st_out        = state_q;

    // Dump sequencer; every output is registered together with the state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            ptr_q       <= '0;
            remaining_q <= '0;
            ram_rd      <= 1'b0;
            ram_adr     <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_adr     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            ram_rd <= 1'b0;
            done   <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (count == '0) begin
                            state_q <= StDone;
                            done    <= 1'b1;
                        end else begin
                            ptr_q       <= start_adr;
                            remaining_q <= count_clamped;
                            ram_rd      <= 1'b1;
                            ram_adr     <= start_adr;
                            state_q     <= StIssue;
                        end
                    end
                end
                StIssue: begin
                    state_q <= StWait;
                end
                StWait: begin
                    out_data  <= ram_data;
                    out_adr   <= ptr_q;
                    out_valid <= 1'b1;
                    state_q   <= StHold;
                end
                StHold: begin
                    if (out_ready) begin
                        out_valid   <= 1'b0;
                        ptr_q       <= ptr_q + 1'b1;
                        remaining_q <= remaining_q - 1'b1;
                        if (remaining_q == (AW + 1)'(1)) begin
                            state_q <= StDone;
                            done    <= 1'b1;
                        end else begin
                            // Next read is issued straight away with the wrapped address.
                            state_q <= StIssue;
                            ram_rd  <= 1'b1;
                            ram_adr <= ptr_q + 1'b1;
                        end
                    end
                end
                StDone: begin
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

`ifdef PRODUCT_READER_CHECKSUM_EN
    logic [DW-1:0] checksum_q;

    // Running sum: cleared on an accepted start, accumulates each accepted word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            checksum_q <= '0;
        end else if (accept) begin
            checksum_q <= '0;
        end else if (handshake) begin
            checksum_q <= checksum_q + out_data;
        end
    end

    assign checksum = checksum_q;
`else
    logic unused_cs;
    assign unused_cs = accept ^ handshake;
    assign checksum  = '0;
`endif

endmodule
